cim_macro_ctrl: RTL and testbench
=================================

# cim_macro_ctrl

Compute-in-memory macro controller sitting directly downstream of the RISC-V core's CIM port. It decodes the core's CIM strobes (`web`, `cimeb`, `partial_sum_eb`, `reset_output_reg`, `output_reg`, `address`, `input_data`) and services four operations:
- weight-row writes and reads to a local weight array;
- multi-cycle signed int8 dot-product accumulation into a bank of output registers;
- output-register readback on `cim_output`.

It stalls the core through the core's `HLT` input while a compute is in flight.

## Interface
- `ROWS`, 64: weight array depth in 32-bit rows; `AW = $clog2(ROWS)`.
- `NACC`, 16: number of 32-bit accumulator (output) registers; fixed by the 4-bit `output_reg` field.
- `CLK` in 1: single clock, rising edge.
- `RESN` in 1: asynchronous, active-low reset.
- `web` in 1: weight-row write strobe.
- `cimeb` in 1: CIM-array enable (compute, register read, register reset).
- `partial_sum_eb` in 1: with `cimeb`, requests a compute/accumulate.
- `reset_output_reg` in 1: with `cimeb`, clears all accumulators.
- `output_reg` in 4: accumulator index for register read.
- `address` in 32: `[AW-1:0]` selects the weight row; `[AW+3:AW]` selects the accumulator target of a compute.
- `input_data` in 32: write data, or compute activations (4 signed int8 lanes, lane0 = `[7:0]`).
- `cim_output` out 32: read data returned to the core.
- `HLT` out 1: stall request to the core.

## Operation
- Request decode uses priority order; only the highest matching request acts, lower ones are ignored.
  1. CLR: `cimeb & reset_output_reg`.
  2. COMP: `cimeb & partial_sum_eb`.
  3. RRD: `cimeb` alone.
  4. WR: `web`.
  5. Otherwise RD/idle.
- WR: at the clock edge, `W[address[AW-1:0]] <= input_data`. Single cycle, no stall.
- RD/idle: `cim_output = W[address[AW-1:0]]`, combinational.
- RRD: `cim_output = ACC[output_reg]`, combinational, no stall.
- CLR: at the clock edge, all `ACC[i] <= 0`. Single cycle, no stall.
- COMP: `ACC[t] += sum over lanes k=0..3 of sx(W[row].lane k) * sx(input_data.lane k)`.
  - `t = address[AW+3:AW]`, `row = address[AW-1:0]`.
  - Each lane product is 16-bit signed, sign-extended to 32 bits.
  - The accumulator wraps modulo 2^32.
- Address bits above `AW+3` are ignored; row and target indices wrap within their fields.
- FSM states:
  - IDLE: if a COMP request is seen, assert `HLT` combinationally in the same cycle; at the edge, latch the row word, activations and `t`; go to MAC with lane=0.
  - MAC: `HLT`=1. Each edge adds the product for the current lane to `ACC[t]` and increments lane. From lane 3, go to DONE.
  - DONE: `HLT`=0 and all requests are ignored for this cycle, so the still-visible COMP strobe does not retrigger. Go to IDLE.
- While `HLT`=1, the core holds its instruction and the strobes stay stable. Strobes are ignored in MAC.
- Weights used by a compute are the values latched in IDLE.
- The weight array is not reset; its contents survive `RESN`.
- Reset: `RESN` low asynchronously forces the following, regardless of other inputs, until `RESN` rises:
  - FSM to IDLE, lane to 0, all ACC to 0, `HLT`=0;
  - `cim_output`=0.
- A compute interrupted by reset is abandoned with no partial result.

## Timing
- COMP: `HLT` is high for 5 consecutive cycles (IDLE detect + MAC lanes 0-3), then low for the DONE cycle, in which the core retires the instruction.
- `ACC[t]` holds its final value after the 4th MAC edge.
- Back-to-back COMP: the next request is accepted in the cycle after DONE, giving a throughput of 6 cycles per compute.
- WR then RD of the same row: the new data is visible on `cim_output` in the cycle after the write edge.
- COMP then RRD of the same `t`: the RRD observes the final sum; the DONE cycle guarantees ordering.
- CLR in the cycle after DONE clears the just-accumulated value.
- `cim_output` and `HLT` are combinational from state, strobes and storage; there is no added latency.

## Test plan
- Reset: hold `RESN`=0 with random strobes -> `HLT`=0, `cim_output`=0. After release, RRD of every index returns 0.
- WR row 3 = 0x01020304, then RD `address`=3 -> `cim_output`=0x01020304 on the next cycle; `HLT` stays 0.
- COMP `address`={t=2,row=3}, `input_data`=0x01010101 -> `HLT` high exactly 5 cycles, then 1 low cycle; RRD `output_reg`=2 returns 10 (0x0000000A).
- Second COMP at the same target with `input_data`=0xFFFFFFFF -> `ACC[2]`=0. A third COMP gives 0xFFFFFFF6, covering wrap and sign extension. Back-to-back spacing is 6 cycles, with no retrigger in DONE.
- Priority: `cimeb`=`partial_sum_eb`=`reset_output_reg`=1 -> all ACC cleared, `HLT` never asserted. `web`=1 with `cimeb`=1 -> no weight write.
- Reset mid-compute: drop `RESN` during MAC lane 2 -> `HLT` falls immediately, `ACC[t]`=0, FSM in IDLE. Weight row 3 still reads 0x01020304.

Source files
------------

// File: rtl/cim_macro_ctrl.sv
// CIM macro controller: weight-row storage, signed int8 4-lane dot-product
// accumulation into 16 output registers, and core stall while a compute runs.
module cim_macro_ctrl #(
    parameter int ROWS = 64,
    parameter int NACC = 16
) (
    input  logic        CLK,
    input  logic        RESN,
    input  logic        web,
    input  logic        cimeb,
    input  logic        partial_sum_eb,
    input  logic        reset_output_reg,
    input  logic [3:0]  output_reg,
    input  logic [31:0] address,
    input  logic [31:0] input_data,
    output logic [31:0] cim_output,
    output logic        HLT
);

    localparam int AW = $clog2(ROWS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [1:0]     lane;
    logic [31:0]    w_lat;
    logic [31:0]    a_lat;
    logic [3:0]     tgt;
    logic [31:0]    wmem [ROWS];
    logic [31:0]    acc  [NACC];

    logic [AW-1:0]  row;
    logic [3:0]     addr_tgt;
    logic           unused_addr_hi;
    logic           idle;
    logic           req_clr, req_comp, req_rrd, req_wr;

    assign row            = address[AW-1:0];
    assign addr_tgt       = address[AW+3:AW];
    assign unused_addr_hi = ^address[31:AW+4];
    assign idle           = (state == S_IDLE);

    // Priority decode: CLR > COMP > RRD > WR > RD.
    assign req_clr  = cimeb & reset_output_reg;
    assign req_comp = cimeb & partial_sum_eb & ~reset_output_reg;
    assign req_rrd  = cimeb & ~partial_sum_eb & ~reset_output_reg;
    assign req_wr   = web & ~cimeb;

    logic signed [7:0]  w_b, a_b;
    logic signed [15:0] prod;
    logic [31:0]        prod_ext;

    assign w_b      = w_lat[{lane, 3'b000} +: 8];
    assign a_b      = a_lat[{lane, 3'b000} +: 8];
    assign prod     = w_b * a_b;
    assign prod_ext = {{16{prod[15]}}, prod};

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        HLT      = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_comp) begin
                    HLT      = 1'b1;
                    state_nx = S_MAC;
                end
            end
            S_MAC: begin
                HLT = 1'b1;
                if (lane == 2'd3) state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (!RESN) HLT = 1'b0;
    end

    always_comb begin
        cim_output = wmem[row];
        if (!RESN)
            cim_output = '0;
        else if (idle && req_rrd)
            cim_output = acc[output_reg];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge CLK or negedge RESN) begin
        if (!RESN) begin
            state <= S_IDLE;
            lane  <= 2'd0;
            w_lat <= '0;
            a_lat <= '0;
            tgt   <= '0;
            for (int i = 0; i < NACC; i++) acc[i] <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (req_clr) begin
                        for (int i = 0; i < NACC; i++) acc[i] <= '0;
                    end else if (req_comp) begin
                        w_lat <= wmem[row];
                        a_lat <= input_data;
                        tgt   <= addr_tgt;
                        lane  <= 2'd0;
                    end
                end
                S_MAC: begin
                    acc[tgt] <= acc[tgt] + prod_ext;
                    lane     <= lane + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the weight array deliberately has no reset so weights survive RESN;
    // writes are still suppressed while RESN is held low.
    always_ff @(posedge CLK) begin
        if (RESN && idle && req_wr) wmem[row] <= input_data;
    end

endmodule

// File: tb/tb_cim_macro_ctrl.sv
// Self-checking bench for cim_macro_ctrl: directed scenarios plus random
// traffic, compared every cycle against a transaction-level model.
module tb_cim_macro_ctrl;

    logic        CLK;
    logic        RESN;
    logic        web, cimeb, partial_sum_eb, reset_output_reg;
    logic [3:0]  output_reg;
    logic [31:0] address, input_data;
    logic [31:0] cim_output;
    logic        HLT;

    int n_cmp = 0;
    int n_bad = 0;

    cim_macro_ctrl #(.ROWS(64), .NACC(16)) dut (
        .CLK              (CLK),
        .RESN             (RESN),
        .web              (web),
        .cimeb            (cimeb),
        .partial_sum_eb   (partial_sum_eb),
        .reset_output_reg (reset_output_reg),
        .output_reg       (output_reg),
        .address          (address),
        .input_data       (input_data),
        .cim_output       (cim_output),
        .HLT              (HLT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: weights and accumulators as plain arrays; a compute is applied
    // whole at acceptance, and ph counts cycles since acceptance (1..4 MAC, 5 DONE).
    logic [31:0] m_w   [64];
    bit          m_wv  [64];
    logic [31:0] m_acc [16];
    int          m_ph = 0;

    function automatic logic [31:0] dot4(input logic [31:0] w, input logic [31:0] a);
        int s = 0;
        for (int k = 0; k < 4; k++) begin
            int wi, ai;
            wi = int'($signed(w[8*k +: 8]));
            ai = int'($signed(a[8*k +: 8]));
            s  = s + wi * ai;
        end
        return 32'(s);
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) m_acc[i] = '0;
        for (int i = 0; i < 64; i++) m_wv[i] = 1'b0;
    end

    always @(negedge CLK) begin
        logic       clr, comp, rrd, wr;
        logic [5:0] r;
        logic [3:0] t;
        clr  = cimeb && reset_output_reg;
        comp = cimeb && partial_sum_eb && !reset_output_reg;
        rrd  = cimeb && !partial_sum_eb && !reset_output_reg;
        wr   = web && !cimeb;
        r    = address[5:0];
        t    = address[9:6];
        if (!RESN) begin
            check("hlt_in_reset", {31'd0, HLT}, 32'd0);
            check("out_in_reset", cim_output, 32'd0);
            m_ph = 0;
            for (int i = 0; i < 16; i++) m_acc[i] = '0;
        end else begin
            check("hlt", {31'd0, HLT},
                  {31'd0, (m_ph >= 1 && m_ph <= 4) || (m_ph == 0 && comp)});
            if (m_ph == 0 && rrd)
                check("rrd", cim_output, m_acc[output_reg]);
            else if (m_ph == 0 && !cimeb && !web && m_wv[r])
                check("rd", cim_output, m_w[r]);
            if (m_ph == 0) begin
                if (clr) begin
                    for (int i = 0; i < 16; i++) m_acc[i] = '0;
                end else if (comp) begin
                    m_acc[t] = m_acc[t] + dot4(m_w[r], input_data);
                    m_ph = 1;
                end else if (wr) begin
                    m_w[r]  = input_data;
                    m_wv[r] = 1'b1;
                end
            end else if (m_ph == 5) begin
                m_ph = 0;
            end else begin
                m_ph = m_ph + 1;
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic w, input logic c, input logic p, input logic ro,
                         input logic [3:0] oreg, input logic [31:0] a, input logic [31:0] d);
        web = w; cimeb = c; partial_sum_eb = p; reset_output_reg = ro;
        output_reg = oreg; address = a; input_data = d;
    endtask

    function automatic logic [31:0] mk_addr(input logic [3:0] t, input logic [5:0] r);
        logic [31:0] a;
        a = $urandom();
        a[9:0] = {t, r};
        return a;
    endfunction

    task automatic do_comp(input string name, input logic [3:0] t, input logic [5:0] r,
                           input logic [31:0] d);
        logic [5:0] pat;
        drive(0, 1, 1, 0, 4'($urandom()), mk_addr(t, r), d);
        for (int i = 0; i < 6; i++) begin
            #2 pat[i] = HLT;
            @(posedge CLK);
            #1;
        end
        check(name, {26'd0, pat}, {26'd0, 6'b011111});
    endtask

    initial begin
        logic [31:0] saved;
        logic [31:0] r;

        RESN = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        for (int i = 0; i < 5; i++) begin
            r = $urandom();
            drive(r[0], r[1], r[2], r[3], r[7:4], $urandom(), $urandom());
            #2 check("rst_hlt_lit", {31'd0, HLT}, 32'd0);
            cyc();
        end
        RESN = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        cyc();

        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 0, 0, 4'(i), $urandom(), $urandom());
            #2 check("rrd_after_reset_lit", cim_output, 32'd0);
            cyc();
        end

        for (int i = 0; i < 64; i++) begin
            drive(1, 0, 0, 0, 0, {$urandom_range(0, 1023), 16'd0, 10'(i)}, $urandom());
            cyc();
        end

        drive(1, 0, 0, 0, 0, 32'd3, 32'h0102_0304);
        #2 check("wr_no_hlt_lit", {31'd0, HLT}, 32'd0);
        cyc();
        drive(0, 0, 0, 0, 0, 32'd3, 32'd0);
        #2 check("rd_row3_lit", cim_output, 32'h0102_0304);
        cyc();

        do_comp("comp1_hlt_pattern", 4'd2, 6'd3, 32'h0101_0101);
        drive(0, 1, 0, 0, 4'd2, 32'd0, 32'd0);
        #2 check("acc2_is_10_lit", cim_output, 32'h0000_000A);
        cyc();

        do_comp("comp2_hlt_pattern", 4'd2, 6'd3, 32'hFFFF_FFFF);
        do_comp("comp3_hlt_pattern", 4'd2, 6'd3, 32'hFFFF_FFFF);
        drive(0, 1, 0, 0, 4'd2, 32'd0, 32'd0);
        #2 check("acc2_wrap_lit", cim_output, 32'hFFFF_FFF6);
        cyc();

        drive(0, 1, 1, 1, 0, mk_addr(4'd2, 6'd3), 32'h7F7F_7F7F);
        #2 check("prio_clr_no_hlt_lit", {31'd0, HLT}, 32'd0);
        cyc();
        drive(0, 1, 0, 0, 4'd2, 32'd0, 32'd0);
        #2 check("acc2_cleared_lit", cim_output, 32'd0);
        cyc();

        saved = m_w[5];
        drive(1, 1, 0, 0, 4'd0, 32'd5, ~saved);
        cyc();
        drive(0, 0, 0, 0, 0, 32'd5, 32'd0);
        #2 check("prio_no_write", cim_output, saved);
        cyc();

        drive(0, 1, 1, 0, 0, mk_addr(4'd4, 6'd3), 32'h0505_0505);
        for (int i = 0; i < 3; i++) cyc();
        RESN = 1'b0;
        #2 check("mid_reset_hlt_lit", {31'd0, HLT}, 32'd0);
        cyc();
        RESN = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        cyc();
        drive(0, 1, 0, 0, 4'd4, 32'd0, 32'd0);
        #2 check("mid_reset_acc4_lit", cim_output, 32'd0);
        cyc();
        drive(0, 0, 0, 0, 0, 32'd3, 32'd0);
        #2 check("weights_survive_lit", cim_output, 32'h0102_0304);
        cyc();

        for (int n = 0; n < 250; n++) begin
            r = $urandom();
            drive(r[0], r[1], r[2], (r[7:4] == 4'd0), r[11:8], $urandom(), $urandom());
            if (r[1] && r[2] && (r[7:4] != 4'd0)) begin
                for (int i = 0; i < 6; i++) cyc();
            end else begin
                cyc();
            end
        end

        drive(0, 0, 0, 0, 0, 0, 0);
        cyc();
        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
